// File: rtl/sn_stream_decoder_if.sv
// rtl/sn_stream_decoder_if.sv - control, sample stream and result bundle for the SN stream decoder
interface sn_stream_decoder_if #(
  parameter int WIN_LOG2_MAX = 7
);
  localparam int CW = WIN_LOG2_MAX + 1;

  logic                 start;
  logic [2:0]           win_sel;
  logic                 cont;
  logic                 sn_valid;
  logic                 sn_bit;
  logic [CW-1:0]        ones_count;
  logic signed [CW:0]   bipolar;
  logic                 result_valid;
  logic                 busy;

  // Upstream side: drives control and the stochastic stream, observes results.
  modport master (
    output start, win_sel, cont, sn_valid, sn_bit,
    input  ones_count, bipolar, result_valid, busy
  );

  // Decoder side.
  modport slave (
    input  start, win_sel, cont, sn_valid, sn_bit,
    output ones_count, bipolar, result_valid, busy
  );
endinterface

// File: rtl/sn_stream_decoder.sv
// rtl/sn_stream_decoder.sv - bipolar stochastic bitstream to binary decoder over a 2^k sample window
module sn_stream_decoder #(
  parameter int WIN_LOG2_MAX = 7
) (
  input  logic               clk,
  input  logic               rst_n,
  sn_stream_decoder_if.slave bus
);
  localparam int CW = WIN_LOG2_MAX + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [CW-1:0] ONE_W = {{(CW-1){1'b0}}, 1'b1};

  state_t             state_q, state_d;
  logic [CW-1:0]      win_n_q;       // window length N = 2^k, latched on start
  logic               cont_q;
  logic [CW-1:0]      sample_cnt_q;  // accepted samples so far in this window (0..N-1)
  logic [CW-1:0]      acc_q;         // ones so far in this window
  logic [CW-1:0]      ones_q;
  logic signed [CW:0] bip_q;
  logic               rv_q;

  logic [2:0]         k_sel;
  logic [CW-1:0]      win_n_sel;
  logic               accept;
  logic               last_sample;
  logic [CW-1:0]      acc_sum;
  logic [CW:0]        bip_sum;

  // Clamp the requested exponent into [3..WIN_LOG2_MAX] and form N.
  always_comb begin
    k_sel = 3'd3;
    if (int'(bus.win_sel) > WIN_LOG2_MAX) begin
      k_sel = 3'(WIN_LOG2_MAX);
    end else if (bus.win_sel > 3'd3) begin
      k_sel = bus.win_sel;
    end
    win_n_sel = ONE_W << k_sel;
  end

  // A start always wins over a sample in the same cycle, so a coincident Nth sample is dropped.
  assign accept      = (state_q == ACCUM) && bus.sn_valid && !bus.start;
  assign last_sample = accept && (sample_cnt_q == (win_n_q - ONE_W));
  assign acc_sum     = acc_q + {{(CW-1){1'b0}}, bus.sn_bit};
  assign bip_sum     = {acc_sum, 1'b0} - {1'b0, win_n_q};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: start restarts from any state; window completion either loops or parks in HOLD.
  always_comb begin
    state_d = state_q;
    if (bus.start) begin
      state_d = ACCUM;
    end else if (last_sample) begin
      state_d = cont_q ? ACCUM : HOLD;
    end
  end

  // Window configuration and sample/ones counters; cleared on start and on window completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_n_q      <= '0;
      cont_q       <= 1'b0;
      sample_cnt_q <= '0;
      acc_q        <= '0;
    end else if (bus.start) begin
      win_n_q      <= win_n_sel;
      cont_q       <= bus.cont;
      sample_cnt_q <= '0;
      acc_q        <= '0;
    end else if (last_sample) begin
      sample_cnt_q <= '0;
      acc_q        <= '0;
    end else if (accept) begin
      sample_cnt_q <= sample_cnt_q + ONE_W;
      acc_q        <= acc_sum;
    end
  end

  // Result registers: updated only by a completed window, strobed for exactly one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ones_q <= '0;
      bip_q  <= '0;
      rv_q   <= 1'b0;
    end else begin
      rv_q <= last_sample;
      if (last_sample) begin
        ones_q <= acc_sum;
        bip_q  <= bip_sum;
      end
    end
  end

  assign bus.ones_count   = ones_q;
  assign bus.bipolar      = bip_q;
  assign bus.result_valid = rv_q;
  assign bus.busy         = (state_q == ACCUM);

endmodule

// File: tb/tb_sn_stream_decoder.sv
// tb/tb_sn_stream_decoder.sv - directed self-checking bench for sn_stream_decoder
module tb_sn_stream_decoder;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   pulse_cnt;
  int   cyc;

  sn_stream_decoder_if #(.WIN_LOG2_MAX(7)) bus ();

  sn_stream_decoder #(.WIN_LOG2_MAX(7)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one cycle of inputs, then sample 1 time unit after the edge.
  task automatic step(input logic st, input logic [2:0] ws, input logic c,
                      input logic v, input logic b);
    bus.start    = st;
    bus.win_sel  = ws;
    bus.cont     = c;
    bus.sn_valid = v;
    bus.sn_bit   = b;
    @(posedge clk);
    #1;
    cyc++;
    if (bus.result_valid === 1'b1) pulse_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(0, 3'd0, 0, 0, 0);
    step(0, 3'd0, 0, 0, 0);
    rst_n = 1'b1;
    step(0, 3'd0, 0, 0, 0);
    total++; if (bus.ones_count !== 8'd0) begin bad++; $display("FAIL reset_ones got=%0d exp=0", bus.ones_count); end
    total++; if (bus.bipolar !== 9'sd0) begin bad++; $display("FAIL reset_bip got=%0d exp=0", bus.bipolar); end
    total++; if (bus.result_valid !== 1'b0) begin bad++; $display("FAIL reset_rv got=%b exp=0", bus.result_valid); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
  endtask

  task automatic test_all_ones();
    step(1, 3'd3, 0, 0, 0);
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL ones_busy got=%b exp=1", bus.busy); end
    pulse_cnt = 0;
    for (int i = 0; i < 7; i++) step(0, 3'd0, 0, 1, 1);
    total++; if (pulse_cnt !== 0) begin bad++; $display("FAIL ones_early_pulse got=%0d exp=0", pulse_cnt); end
    step(0, 3'd0, 0, 1, 1);
    total++; if (bus.result_valid !== 1'b1) begin bad++; $display("FAIL ones_rv got=%b exp=1", bus.result_valid); end
    total++; if (bus.ones_count !== 8'd8) begin bad++; $display("FAIL ones_count got=%0d exp=8", bus.ones_count); end
    total++; if (bus.bipolar !== 9'sd8) begin bad++; $display("FAIL ones_bip got=%0d exp=8", bus.bipolar); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL ones_busy_after got=%b exp=0", bus.busy); end
    step(0, 3'd0, 0, 1, 0);
    total++; if (bus.result_valid !== 1'b0) begin bad++; $display("FAIL ones_rv_single got=%b exp=0", bus.result_valid); end
    total++; if (bus.ones_count !== 8'd8) begin bad++; $display("FAIL ones_hold got=%0d exp=8", bus.ones_count); end
  endtask

  task automatic test_gapped_alternating();
    int acc_n;
    int i;
    step(1, 3'd4, 0, 0, 0);
    pulse_cnt = 0;
    acc_n = 0;
    i = 0;
    while (acc_n < 16 && i < 100) begin
      if (i % 3 == 2) begin
        step(0, 3'd0, 0, 0, 1);
      end else begin
        step(0, 3'd0, 0, 1, (acc_n % 2 == 0));
        acc_n++;
        if (acc_n == 15) begin
          total++; if (pulse_cnt !== 0) begin bad++; $display("FAIL alt_early_pulse got=%0d exp=0", pulse_cnt); end
        end
      end
      i++;
    end
    total++; if (bus.result_valid !== 1'b1) begin bad++; $display("FAIL alt_rv got=%b exp=1", bus.result_valid); end
    total++; if (bus.ones_count !== 8'd8) begin bad++; $display("FAIL alt_count got=%0d exp=8", bus.ones_count); end
    total++; if (bus.bipolar !== 9'sd0) begin bad++; $display("FAIL alt_bip got=%0d exp=0", bus.bipolar); end
  endtask

  task automatic test_back_to_back();
    int c1;
    step(1, 3'd0, 1, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 3'd0, 0, 1, 1);
    c1 = cyc;
    total++; if (bus.result_valid !== 1'b1) begin bad++; $display("FAIL b2b_rv1 got=%b exp=1", bus.result_valid); end
    total++; if (bus.ones_count !== 8'd8) begin bad++; $display("FAIL b2b_count1 got=%0d exp=8", bus.ones_count); end
    total++; if (bus.bipolar !== 9'sd8) begin bad++; $display("FAIL b2b_bip1 got=%0d exp=8", bus.bipolar); end
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL b2b_busy1 got=%b exp=1", bus.busy); end
    pulse_cnt = 0;
    for (int i = 0; i < 8; i++) step(0, 3'd0, 0, 1, 0);
    total++; if (pulse_cnt !== 1 || bus.result_valid !== 1'b1) begin bad++; $display("FAIL b2b_rv2 got=%0d/%b exp=1/1", pulse_cnt, bus.result_valid); end
    total++; if (cyc - c1 !== 8) begin bad++; $display("FAIL b2b_spacing got=%0d exp=8", cyc - c1); end
    total++; if (bus.ones_count !== 8'd0) begin bad++; $display("FAIL b2b_count2 got=%0d exp=0", bus.ones_count); end
    total++; if (bus.bipolar !== -9'sd8) begin bad++; $display("FAIL b2b_bip2 got=%0d exp=-8", bus.bipolar); end
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL b2b_busy2 got=%b exp=1", bus.busy); end
  endtask

  task automatic test_abort();
    pulse_cnt = 0;
    step(1, 3'd3, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 3'd0, 0, 1, 1);
    step(1, 3'd3, 0, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 3'd0, 0, 1, (i < 3));
    total++; if (pulse_cnt !== 0) begin bad++; $display("FAIL abort_pulse got=%0d exp=0", pulse_cnt); end
    total++; if (bus.ones_count !== 8'd0 || bus.bipolar !== -9'sd8) begin bad++; $display("FAIL abort_held got=%0d/%0d exp=0/-8", bus.ones_count, bus.bipolar); end
    step(0, 3'd0, 0, 1, 0);
    total++; if (bus.result_valid !== 1'b1) begin bad++; $display("FAIL abort_rv got=%b exp=1", bus.result_valid); end
    total++; if (bus.ones_count !== 8'd3) begin bad++; $display("FAIL abort_count got=%0d exp=3", bus.ones_count); end
    total++; if (bus.bipolar !== -9'sd2) begin bad++; $display("FAIL abort_bip got=%0d exp=-2", bus.bipolar); end
    // Start coincident with the 8th sample discards that window.
    step(1, 3'd3, 0, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 3'd0, 0, 1, 1);
    step(1, 3'd3, 0, 1, 1);
    total++; if (bus.result_valid !== 1'b0 || bus.ones_count !== 8'd3) begin bad++; $display("FAIL coincide got=%b/%0d exp=0/3", bus.result_valid, bus.ones_count); end
    for (int i = 0; i < 8; i++) step(0, 3'd0, 0, 1, 1);
    total++; if (bus.result_valid !== 1'b1 || bus.ones_count !== 8'd8) begin bad++; $display("FAIL coincide_next got=%b/%0d exp=1/8", bus.result_valid, bus.ones_count); end
  endtask

  task automatic test_async_reset();
    step(1, 3'd3, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 3'd0, 0, 1, 1);
    #2 rst_n = 1'b0;
    #1;
    total++; if (bus.ones_count !== 8'd0 || bus.bipolar !== 9'sd0) begin bad++; $display("FAIL arst_out got=%0d/%0d exp=0/0", bus.ones_count, bus.bipolar); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL arst_busy got=%b exp=0", bus.busy); end
    step(0, 3'd0, 0, 1, 1);
    rst_n = 1'b1;
    pulse_cnt = 0;
    for (int i = 0; i < 10; i++) step(0, 3'd0, 0, 1, 1);
    total++; if (pulse_cnt !== 0 || bus.busy !== 1'b0) begin bad++; $display("FAIL arst_idle got=%0d/%b exp=0/0", pulse_cnt, bus.busy); end
  endtask

  task automatic test_random_window();
    int model;
    logic b;
    logic signed [8:0] exp_bip;
    model = 0;
    step(1, 3'd7, 0, 0, 0);
    pulse_cnt = 0;
    for (int i = 0; i < 128; i++) begin
      b = ($urandom_range(0, 3) != 0);
      if (b) model++;
      step(0, 3'd0, 0, 1, b);
    end
    exp_bip = 9'(2 * model - 128);
    total++; if (bus.result_valid !== 1'b1 || pulse_cnt !== 1) begin bad++; $display("FAIL rand_rv got=%b/%0d exp=1/1", bus.result_valid, pulse_cnt); end
    total++; if (bus.ones_count !== 8'(model)) begin bad++; $display("FAIL rand_count got=%0d exp=%0d", bus.ones_count, model); end
    total++; if (bus.bipolar !== exp_bip) begin bad++; $display("FAIL rand_bip got=%0d exp=%0d", bus.bipolar, exp_bip); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    pulse_cnt = 0;
    cyc = 0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.win_sel = 3'd0;
    bus.cont = 1'b0;
    bus.sn_valid = 1'b0;
    bus.sn_bit = 1'b0;
    test_reset();
    test_all_ones();
    test_gapped_alternating();
    test_back_to_back();
    test_abort();
    test_async_reset();
    test_random_window();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
